// File: rtl/pwm_capture.sv
// pwm_capture: measures an external PWM input in prescaled ticks.
// Reports the period (rising edge to rising edge) and the high time (rising to
// falling edge). A TIMEOUT-tick watchdog flags a lost signal or a stuck 0 %/100 %
// duty input.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// WAIT_RISE | unarmed; the next rising edge starts a measurement
// HIGH      | input high, counting high time
// LOW       | input low after the falling edge, waiting for the closing rise

module pwm_capture #(
   parameter int PRESCALE = 250,
   parameter int WIDTH    = 16,
   parameter int TIMEOUT  = 20000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             level
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int TO_W = WIDTH + 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [TO_W-1:0]  TO_VAL  = TO_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_WAIT_RISE = 2'd0,
      ST_HIGH      = 2'd1,
      ST_LOW       = 2'd2
   } state_t;

   state_t           state;
   logic             sync_1;
   logic             level_prev;
   logic [PS_W-1:0]  ps_cnt;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] hi_lat;

   logic             tick;
   logic             rise;
   logic             fall;
   logic [TO_W-1:0]  cnt_next_ext;
   logic             to_hit;

   assign tick         = (ps_cnt == PS_LAST);
   assign rise         = level & ~level_prev;
   assign fall         = ~level & level_prev;
   assign cnt_next_ext = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
   // Compare with >= so a tick swallowed by a coincident fall cannot step past
   // the threshold and disable the watchdog for the rest of the measurement.
   assign to_hit       = tick && (cnt_next_ext >= TO_VAL);

   // Two-flop synchronizer for the asynchronous input, plus a history flop for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1     <= 1'b0;
         level      <= 1'b0;
         level_prev <= 1'b0;
      end else begin
         sync_1     <= pwm_in;
         level      <= sync_1;
         level_prev <= level;
      end
   end

   // Free-running tick prescaler; edges never restart it, so tick phase is fixed by reset only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ps_cnt <= '0;
      end else if (tick) begin
         ps_cnt <= '0;
      end else begin
         ps_cnt <= ps_cnt + 1'b1;
      end
   end

   // Measurement FSM: owns the tick counter, the high-time latch and all registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_WAIT_RISE;
         cnt       <= '0;
         hi_lat    <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (tick && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
         end

         case (state)
            ST_WAIT_RISE: begin
               if (rise) begin
                  cnt   <= '0;
                  state <= ST_HIGH;
               end else if (to_hit) begin
                  timeout   <= 1'b1;
                  period    <= '0;
                  high_time <= '0;
                  cnt       <= '0;
                  state     <= ST_WAIT_RISE;
               end
            end

            ST_HIGH: begin
               if (fall) begin
                  hi_lat <= cnt;
                  state  <= ST_LOW;
               end else if (to_hit) begin
                  timeout   <= 1'b1;
                  period    <= '0;
                  high_time <= '0;
                  cnt       <= '0;
                  state     <= ST_WAIT_RISE;
               end
            end

            ST_LOW: begin
               if (rise) begin
                  period    <= cnt;
                  high_time <= hi_lat;
                  valid     <= 1'b1;
                  timeout   <= 1'b0;
                  cnt       <= '0;
                  state     <= ST_HIGH;
               end else if (to_hit) begin
                  timeout   <= 1'b1;
                  period    <= '0;
                  high_time <= '0;
                  cnt       <= '0;
                  state     <= ST_WAIT_RISE;
               end
            end

            default: begin
               cnt   <= '0;
               state <= ST_WAIT_RISE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture with a fast time base (4 clocks per tick, 100-tick timeout).
// PWM edges are driven on clock counts that are multiples of 4 after reset, so the
// detected edge lands 3 clocks later, between ticks, and the tick counts are exact.

module tb_pwm_capture;

   localparam int PRESCALE = 4;
   localparam int WIDTH    = 16;
   localparam int TIMEOUT  = 100;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             pwm_in = 1'b0;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high_time;
   logic             valid;
   logic             timeout;
   logic             level;

   typedef struct {
      int high_clk;
      int per_clk;
      int reps;
      int exp_period;
      int exp_high;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] period;
      logic [WIDTH-1:0] high_time;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   armed    = 1'b0;
   bit   last_ok  = 1'b1;
   int   last_per = 0;
   int   last_high = 0;

   pwm_capture #(
      .PRESCALE(PRESCALE),
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .pwm_in   (pwm_in),
      .period   (period),
      .high_time(high_time),
      .valid    (valid),
      .timeout  (timeout),
      .level    (level)
   );

   always #5 clock = ~clock;

   // Clock edges since reset release; aligns stimulus with the prescaler phase.
   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every valid pulse must match the oldest expected measurement.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got valid with period=%0d high_time=%0d, expected no valid (t=%0t)",
                     period, high_time, $time);
         end else begin
            e = sb_q.pop_front();
            check("valid_period", 32'(period), 32'(e.period));
            check("valid_high_time", 32'(high_time), 32'(e.high_time));
            check("valid_timeout", 32'(timeout), 32'd0);
         end
      end
   end

   task automatic align();
      for (int k = 0; k < 8; k++) begin
         if ((cyc % 4) == 0) break;
         @(negedge clock);
      end
   endtask

   // Rising edge: closes the previous period; it yields a measurement only if armed
   // and the previous period was shorter than the timeout.
   task automatic do_rise();
      exp_t e;
      if (armed && last_ok) begin
         e.period    = WIDTH'(last_per / PRESCALE);
         e.high_time = WIDTH'(last_high / PRESCALE);
         sb_q.push_back(e);
      end
      armed  = 1'b1;
      pwm_in = 1'b1;
   endtask

   task automatic run_period(input int high_clk, input int per_clk);
      do_rise();
      repeat (high_clk) @(negedge clock);
      pwm_in = 1'b0;
      repeat (per_clk - high_clk) @(negedge clock);
      last_per  = per_clk;
      last_high = high_clk;
      last_ok   = (per_clk / PRESCALE) < TIMEOUT;
   endtask

   initial begin
      vec_t vecs[4];
      vecs[0] = '{40,  160, 3, 40, 10};
      vecs[1] = '{120, 160, 2, 40, 30};
      vecs[2] = '{80,  200, 2, 50, 20};
      vecs[3] = '{4,   160, 2, 40, 1};

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_period", 32'(period), 32'd0);
      check("rst_high_time", 32'(high_time), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      reset = 1'b0;
      align();

      // Table-driven duty/period patterns; values must hold between valid pulses.
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            run_period(vecs[i].high_clk, vecs[i].per_clk);
         end
         check("hold_period", 32'(period), 32'(vecs[i].exp_period));
         check("hold_high_time", 32'(high_time), 32'(vecs[i].exp_high));
         check("hold_timeout", 32'(timeout), 32'd0);
      end

      // Stuck high: timeout on exactly the 100th tick after the detected rise.
      do_rise();
      repeat (399) @(negedge clock);
      check("timeout_not_early", 32'(timeout), 32'd0);
      @(negedge clock);
      check("timeout_set", 32'(timeout), 32'd1);
      check("timeout_period", 32'(period), 32'd0);
      check("timeout_high_time", 32'(high_time), 32'd0);
      check("timeout_level", 32'(level), 32'd1);
      check("timeout_sb_empty", 32'(sb_q.size()), 32'd0);
      last_ok = 1'b0;

      // Recovery: first rise only arms, second rise measures and clears timeout.
      pwm_in = 1'b0;
      repeat (8) @(negedge clock);
      for (int r = 0; r < 3; r++) run_period(40, 160);
      check("recover_timeout", 32'(timeout), 32'd0);
      check("recover_period", 32'(period), 32'd40);
      check("recover_high_time", 32'(high_time), 32'd10);

      // Period longer than the timeout: never valid, timeout stays up.
      for (int r = 0; r < 3; r++) run_period(120, 480);
      check("long_timeout", 32'(timeout), 32'd1);
      check("long_period", 32'(period), 32'd0);
      check("long_high_time", 32'(high_time), 32'd0);
      check("long_sb_empty", 32'(sb_q.size()), 32'd0);

      // Re-lock, then reset while in HIGH.
      for (int r = 0; r < 2; r++) run_period(40, 160);
      do_rise();
      repeat (20) @(negedge clock);
      check("pre_rst_period", 32'(period), 32'd40);
      reset  = 1'b1;
      pwm_in = 1'b0;
      #1;
      check("midrst_period", 32'(period), 32'd0);
      check("midrst_high_time", 32'(high_time), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_timeout", 32'(timeout), 32'd0);
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      armed   = 1'b0;
      last_ok = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      align();
      for (int r = 0; r < 3; r++) run_period(40, 160);
      repeat (10) @(negedge clock);
      check("final_sb_empty", 32'(sb_q.size()), 32'd0);
      check("final_period", 32'(period), 32'd40);
      check("final_high_time", 32'(high_time), 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
